multi_bank_sram: RTL
====================

Name: multi_bank_sram

Overview:
- Parametrised bank of Nums_SRAM independent simple-dual-port SRAMs (one write port, one read port each), every word para_deg lanes of data_width bits.
- Replaces the per-instance Dual_SRAM wiring of the Conv1D datapath (in1, in2 and out buffers) with a single block.
- Adds per-lane write masks, a registered read with a valid flag, configurable read-during-write behaviour and a sequential per-bank clear engine with a busy flag.

Parameters:
- data_width, 8, bits per lane
- addr_width, 4, address bits per bank
- Ram_Depth, 1 << addr_width, words per bank; must be at most 2^addr_width
- Nums_SRAM, 3, number of banks
- para_deg, 4, lanes per word
- Rd_Bypass, 1, same-address read-during-write: 1 returns the new (merged) data, 0 returns the old data

Ports:
- clk  in  1  clock; all logic on the rising edge
- Rst_n  in  1  asynchronous active-low reset
- Clear_Req  in  Nums_SRAM  per-bank request to zero the whole bank
- Chip_Select  in  Nums_SRAM  per-bank enable; 0 means the bank ignores En_Write, En_Read and Clear_Req
- En_Write  in  Nums_SRAM  per-bank write strobe
- En_Read  in  Nums_SRAM  per-bank read strobe
- Write_Addr  in  Nums_SRAM*addr_width  bank b uses slice [b*addr_width +: addr_width]
- Read_Addr  in  Nums_SRAM*addr_width  same slicing as Write_Addr
- Write_Data  in  Nums_SRAM*para_deg*data_width  bank b word at [b*para_deg*data_width +: para_deg*data_width]; lane l inside the word at [l*data_width +: data_width]
- Write_Mask  in  Nums_SRAM*para_deg  bit b*para_deg+l enables lane l of bank b
- Read_Data  out  Nums_SRAM*para_deg*data_width  registered read word, same slicing as Write_Data
- Read_Valid  out  Nums_SRAM  one-cycle pulse marking fresh Read_Data
- Busy  out  Nums_SRAM  bank is clearing

Behaviour:
- Reset (Rst_n low, asynchronous): Read_Data=0, Read_Valid=0, Busy=all 1, every bank FSM forced to CLEAR with clear pointer=0. Memory contents are not reset directly; they are zeroed by the clear sweep.
- Per-bank FSM states: IDLE and CLEAR.
  - CLEAR: writes all-zero to the word at the pointer each cycle; pointer increments; after the word at Ram_Depth-1 is written, go to IDLE and drop Busy on the next edge.
  - Clear duration: exactly Ram_Depth cycles after reset release or after an accepted Clear_Req.
  - IDLE to CLEAR: on Chip_Select & Clear_Req. A clear request has priority over a write or read in the same cycle; that write/read is dropped.
  - In CLEAR: En_Write, En_Read and Clear_Req are ignored, and Read_Valid stays 0.
  - Reset asserted mid-clear restarts the sweep at pointer 0.
- Write (IDLE, Chip_Select & En_Write): lanes with a mask bit of 1 are updated at the edge; masked-off lanes keep their old value. A mask of all 0 is a no-op.
- Read (IDLE, Chip_Select & En_Read):
  - Read_Data is updated at the edge, and Read_Valid=1 for exactly that following cycle (latency 1).
  - With no accepted read, Read_Read_Data holds its last value and Read_Valid=0.
- Same cycle, same address, both read and write accepted:
  - Rd_Bypass=1: Read_Data = stored word with the masked lanes replaced by Write_Data.
  - Rd_Bypass=0: Read_Data = pre-write word.
  - In both cases the memory holds the merged word afterwards.
- Out-of-range address (>= Ram_Depth, possible only when Ram_Depth < 2^addr_width):
  - Write is dropped.
  - Read returns all-zero with Read_Valid=1.
- Banks are fully independent; there is no cross-bank arbitration.
- Clear pointer width is addr_width+1 so that Ram_Depth = 2^addr_width terminates without wrap ambiguity.

Decomposition:
- Shared package conv1d_pkg holds:
  - FSM state enum (ST_IDLE, ST_CLEAR)
  - default DATA_WIDTH, ADDR_WIDTH, PARA_DEG and NUMS_SRAM constants
  - lane-slice helper function (b, l) -> bit offset
- One sub-module, sram_bank: a single bank with its memory array, clear FSM, mask merge and bypass logic.
- The top level is a generate loop of Nums_SRAM sram_bank instances plus port slicing.

Test Plan:
- Reset release: Busy=3'b111 for exactly 16 cycles; then Busy=0. A read of bank1 address 5 then gives Read_Data slice 0 and Read_Valid=1 one cycle after the request.
- Full-mask write: bank0 address 3 = 0x44332211 (mask 4'b1111). Read address 3 next cycle; the following cycle returns 0x44332211 with Read_Valid=1. Banks 1 and 2 at address 3 remain 0.
- Partial mask: bank2 address 7 = 0xAABBCCDD, then write 0x11223344 with mask 4'b0101. A subsequent read returns 0xAA22CC44.
- Collision: bank0 address 2 holds 0x01010101; write 0xFFFFFFFF at address 2 with read of address 2 in the same cycle. Rd_Bypass=1 returns 0xFFFFFFFF; Rd_Bypass=0 returns 0x01010101. Memory is 0xFFFFFFFF afterwards in both builds.
- Clear mid-traffic: Clear_Req to bank1 with a simultaneous write. The write is dropped; Busy[1]=1 for 16 cycles; reads during the sweep give Read_Valid=0. Afterwards every address reads 0. Banks 0 and 2 are unaffected and usable throughout.
- Chip_Select=0 with En_Write, En_Read and Clear_Req all high: no state change, Read_Valid=0. Rst_n pulsed low at clear cycle 8: Busy stays high and the sweep completes 16 cycles after release.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared definitions for the Conv1D buffer banks: default geometry, the
// per-bank clear FSM state type and a lane-offset helper for flat buses.
package conv1d_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int PARA_DEG   = 4;
    localparam int NUMS_SRAM  = 3;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } bank_state_t;

    // Bit offset of lane l of bank b inside a flat multi-bank data bus.
    function automatic int lane_offset(input int b, input int l, input int lanes, input int width);
        return (b * lanes + l) * width;
    endfunction

endpackage

// File: rtl/multi_bank_sram_if.sv
// Flat per-bank request/response bus of the multi-bank SRAM; bank b owns
// slice b of every field.
interface multi_bank_sram_if
    import conv1d_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int addr_width = ADDR_WIDTH,
    parameter int Nums_SRAM  = NUMS_SRAM,
    parameter int para_deg   = PARA_DEG
);

    logic [Nums_SRAM-1:0]                     Clear_Req;
    logic [Nums_SRAM-1:0]                     Chip_Select;
    logic [Nums_SRAM-1:0]                     En_Write;
    logic [Nums_SRAM-1:0]                     En_Read;
    logic [Nums_SRAM*addr_width-1:0]          Write_Addr;
    logic [Nums_SRAM*addr_width-1:0]          Read_Addr;
    logic [Nums_SRAM*para_deg*data_width-1:0] Write_Data;
    logic [Nums_SRAM*para_deg-1:0]            Write_Mask;
    logic [Nums_SRAM*para_deg*data_width-1:0] Read_Data;
    logic [Nums_SRAM-1:0]                     Read_Valid;
    logic [Nums_SRAM-1:0]                     Busy;

    modport master (
        output Clear_Req, Chip_Select, En_Write, En_Read,
        output Write_Addr, Read_Addr, Write_Data, Write_Mask,
        input  Read_Data, Read_Valid, Busy
    );

    modport slave (
        input  Clear_Req, Chip_Select, En_Write, En_Read,
        input  Write_Addr, Read_Addr, Write_Data, Write_Mask,
        output Read_Data, Read_Valid, Busy
    );

endinterface

// File: rtl/sram_bank.sv
// One simple-dual-port bank: lane-masked writes, registered read with valid,
// same-address read-during-write bypass and a sequential zeroing sweep.
module sram_bank
    import conv1d_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int addr_width = ADDR_WIDTH,
    parameter int Ram_Depth  = 1 << addr_width,
    parameter int para_deg   = PARA_DEG,
    parameter int Rd_Bypass  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_req,
    input  logic                           chip_select,
    input  logic                           en_write,
    input  logic                           en_read,
    input  logic [addr_width-1:0]          write_addr,
    input  logic [addr_width-1:0]          read_addr,
    input  logic [para_deg*data_width-1:0] write_data,
    input  logic [para_deg-1:0]            write_mask,
    output logic [para_deg*data_width-1:0] read_data,
    output logic                           read_valid,
    output logic                           busy
);

    localparam int                  WORD_W   = para_deg * data_width;
    localparam logic [addr_width:0] DEPTH    = (addr_width + 1)'(Ram_Depth);
    localparam logic [addr_width:0] PTR_LAST = (addr_width + 1)'(Ram_Depth - 1);

    logic [WORD_W-1:0] mem [Ram_Depth];

    bank_state_t         state_q, state_d;
    logic [addr_width:0] ptr_q, ptr_d;

    logic                  idle, clear_acc, wr_acc, rd_acc;
    logic                  wr_in_range, rd_in_range;
    logic [addr_width-1:0] wr_idx, rd_idx;
    logic [WORD_W-1:0]     old_word, merged_word, rd_word;

    // A clear request wins over a write or read presented in the same cycle.
    assign idle        = (state_q == ST_IDLE);
    assign clear_acc   = idle & chip_select & clear_req;
    assign wr_in_range = ({1'b0, write_addr} < DEPTH);
    assign rd_in_range = ({1'b0, read_addr} < DEPTH);
    assign wr_acc      = idle & chip_select & en_write & ~clear_req & wr_in_range;
    assign rd_acc      = idle & chip_select & en_read & ~clear_req;
    assign wr_idx      = wr_in_range ? write_addr : '0;
    assign rd_idx      = rd_in_range ? read_addr : '0;
    assign busy        = (state_q == ST_CLEAR);
    assign old_word    = mem[wr_idx];

    always_comb begin
        merged_word = old_word;
        for (int l = 0; l < para_deg; l++) begin
            if (write_mask[l]) begin
                merged_word[l*data_width +: data_width] = write_data[l*data_width +: data_width];
            end
        end
    end

    // Out-of-range reads still complete, returning zero.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if ((Rd_Bypass != 0) && wr_acc && (write_addr == read_addr)) begin
                rd_word = merged_word;
            end else begin
                rd_word = mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_acc) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // The array itself is never reset; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[ptr_q[addr_width-1:0]] <= '0;
        end else if (wr_acc) begin
            mem[wr_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_acc;
            if (rd_acc) begin
                read_data <= rd_word;
            end
        end
    end

endmodule

// File: rtl/multi_bank_sram.sv
// Nums_SRAM independent sram_bank instances behind one flat bus, replacing
// the per-buffer Dual_SRAM wiring of the Conv1D datapath.
module multi_bank_sram
    import conv1d_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int addr_width = ADDR_WIDTH,
    parameter int Ram_Depth  = 1 << addr_width,
    parameter int Nums_SRAM  = NUMS_SRAM,
    parameter int para_deg   = PARA_DEG,
    parameter int Rd_Bypass  = 1
) (
    input logic                clk,
    input logic                Rst_n,
    multi_bank_sram_if.slave   bus
);

    localparam int WORD_W = para_deg * data_width;

    logic [WORD_W-1:0] rd_data_bank  [Nums_SRAM];
    logic              rd_valid_bank [Nums_SRAM];
    logic              busy_bank     [Nums_SRAM];

    for (genvar b = 0; b < Nums_SRAM; b++) begin : g_bank
        sram_bank #(
            .data_width (data_width),
            .addr_width (addr_width),
            .Ram_Depth  (Ram_Depth),
            .para_deg   (para_deg),
            .Rd_Bypass  (Rd_Bypass)
        ) u_bank (
            .clk         (clk),
            .rst_n       (Rst_n),
            .clear_req   (bus.Clear_Req[b]),
            .chip_select (bus.Chip_Select[b]),
            .en_write    (bus.En_Write[b]),
            .en_read     (bus.En_Read[b]),
            .write_addr  (bus.Write_Addr[b*addr_width +: addr_width]),
            .read_addr   (bus.Read_Addr[b*addr_width +: addr_width]),
            .write_data  (bus.Write_Data[lane_offset(b, 0, para_deg, data_width) +: WORD_W]),
            .write_mask  (bus.Write_Mask[b*para_deg +: para_deg]),
            .read_data   (rd_data_bank[b]),
            .read_valid  (rd_valid_bank[b]),
            .busy        (busy_bank[b])
        );
    end

    always_comb begin
        bus.Read_Data  = '0;
        bus.Read_Valid = '0;
        bus.Busy       = '0;
        for (int b = 0; b < Nums_SRAM; b++) begin
            bus.Read_Data[lane_offset(b, 0, para_deg, data_width) +: WORD_W] = rd_data_bank[b];
            bus.Read_Valid[b] = rd_valid_bank[b];
            bus.Busy[b]       = busy_bank[b];
        end
    end

endmodule
